// File: rtl/audio_sched_pkg.sv
// Shared types and constants for the time-shared biquad cascade audio_mac_sched.
package audio_sched_pkg;

    typedef logic signed [17:0] coef_t;
    typedef logic signed [15:0] sample_t;
    typedef logic signed [39:0] acc_t;

    typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;

    localparam int unsigned IDX_B0   = 0;
    localparam int unsigned IDX_B1   = 1;
    localparam int unsigned IDX_B2   = 2;
    localparam int unsigned IDX_A1   = 3;
    localparam int unsigned IDX_A2   = 4;
    localparam int unsigned NUM_TAPS = 5;

    localparam coef_t COEF_PASS = 18'sd65536;

endpackage

// File: rtl/audio_mac.sv
// Single shared 16x18 signed multiplier feeding a registered 40-bit accumulator.
module audio_mac
    import audio_sched_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic signed [15:0] a,
    input  logic signed [17:0] b,
    input  logic               acc_en,
    input  logic               clr,
    input  logic               sub,
    output logic signed [39:0] acc
);

    acc_t acc_q, acc_d, prod, base;

    always_comb begin
        prod  = acc_t'(a) * acc_t'(b);
        base  = clr ? '0 : acc_q;
        acc_d = acc_q;
        if (acc_en) begin
            acc_d = sub ? (base - prod) : (base + prod);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/audio_mac_sched.sv
// Stereo biquad cascade sharing one MAC across all stages and channels.
// Optional macro AUDIO_SCHED_SAT_EN: saturate stage outputs instead of wrapping.
module audio_mac_sched
    import audio_sched_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int FRAC   = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          sample_ce,
    input  logic signed [15:0]            in_l,
    input  logic signed [15:0]            in_r,
    input  logic [STAGES-1:0]             en,
    input  logic                          cfg_we,
    input  logic [$clog2(STAGES)+2:0]     cfg_addr,
    input  logic [17:0]                   cfg_data,
    output logic signed [15:0]            out_l,
    output logic signed [15:0]            out_r,
    output logic                          out_valid,
    output logic                          busy,
    output logic                          overrun
);

    localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;

    state_t         state_q, state_d;
    logic [SW-1:0]  stage_q, stage_d;
    logic [2:0]     tap_q, tap_d;
    logic           ch_q, ch_d;
    sample_t        cur_q [2], cur_d [2];
    sample_t        x1_q [STAGES][2], x1_d [STAGES][2];
    sample_t        x2_q [STAGES][2], x2_d [STAGES][2];
    sample_t        y1_q [STAGES][2], y1_d [STAGES][2];
    sample_t        y2_q [STAGES][2], y2_d [STAGES][2];
    coef_t          shd_q [STAGES][NUM_TAPS], shd_d [STAGES][NUM_TAPS];
    coef_t          act_q [STAGES][NUM_TAPS], act_d [STAGES][NUM_TAPS];
    sample_t        out_l_q, out_l_d, out_r_q, out_r_d;
    logic           out_valid_q, out_valid_d, busy_q, busy_d, overrun_q, overrun_d;

    logic [SW-1:0]  wr_stage;
    sample_t        mac_a, y;
    coef_t          mac_b;
    acc_t           acc, shifted;
    logic           mac_en, mac_clr, mac_sub;

    if (STAGES > 1) begin : g_wr_stage
        assign wr_stage = cfg_addr[$clog2(STAGES)+2:3];
    end else begin : g_wr_stage_one
        assign wr_stage = '0;
    end

    audio_mac u_mac (
        .clk    (clk),
        .reset_n(reset_n),
        .a      (mac_a),
        .b      (mac_b),
        .acc_en (mac_en),
        .clr    (mac_clr),
        .sub    (mac_sub),
        .acc    (acc)
    );

    always_comb begin
        unique case (tap_q)
            3'd0:    mac_a = cur_q[ch_q];
            3'd1:    mac_a = x1_q[stage_q][ch_q];
            3'd2:    mac_a = x2_q[stage_q][ch_q];
            3'd3:    mac_a = y1_q[stage_q][ch_q];
            default: mac_a = y2_q[stage_q][ch_q];
        endcase
        mac_b   = act_q[stage_q][tap_q];
        shifted = acc >>> FRAC;
`ifdef AUDIO_SCHED_SAT_EN
        if (shifted > acc_t'(32767)) begin
            y = 16'sh7fff;
        end else if (shifted < acc_t'(-32768)) begin
            y = 16'sh8000;
        end else begin
            y = shifted[15:0];
        end
`else
        y = shifted[15:0];
`endif
    end

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        tap_d       = tap_q;
        ch_d        = ch_q;
        cur_d       = cur_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        shd_d       = shd_q;
        act_d       = act_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        out_valid_d = 1'b0;
        busy_d      = busy_q;
        overrun_d   = overrun_q;
        mac_en      = 1'b0;
        mac_clr     = 1'b0;
        mac_sub     = 1'b0;

        if (cfg_we && (cfg_addr[2:0] < 3'd5) && (32'(wr_stage) < STAGES)) begin
            shd_d[wr_stage][cfg_addr[2:0]] = coef_t'(cfg_data);
        end
        if (sample_ce && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (sample_ce) begin
                    cur_d[0] = in_l;
                    cur_d[1] = in_r;
                    act_d    = shd_q;
                    state_d  = MAC;
                    stage_d  = '0;
                    ch_d     = 1'b0;
                    tap_d    = '0;
                    busy_d   = 1'b1;
                end
            end
            MAC: begin
                mac_en  = 1'b1;
                mac_clr = (tap_q == 3'd0);
                mac_sub = (tap_q >= 3'd3);
                if (tap_q == 3'd4) begin
                    tap_d   = '0;
                    state_d = WB;
                end else begin
                    tap_d = tap_q + 3'd1;
                end
            end
            WB: begin
                // Bypassed stages keep x0 and their histories untouched.
                if (en[stage_q]) begin
                    x2_d[stage_q][ch_q] = x1_q[stage_q][ch_q];
                    x1_d[stage_q][ch_q] = cur_q[ch_q];
                    y2_d[stage_q][ch_q] = y1_q[stage_q][ch_q];
                    y1_d[stage_q][ch_q] = y;
                    cur_d[ch_q]         = y;
                end
                if (!ch_q) begin
                    ch_d    = 1'b1;
                    state_d = MAC;
                end else begin
                    ch_d = 1'b0;
                    if (stage_q == SW'(STAGES - 1)) begin
                        state_d = DONE;
                    end else begin
                        stage_d = stage_q + 1'b1;
                        state_d = MAC;
                    end
                end
            end
            default: begin
                out_l_d     = cur_q[0];
                out_r_d     = cur_q[1];
                out_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            stage_q     <= '0;
            tap_q       <= '0;
            ch_q        <= 1'b0;
            cur_q[0]    <= '0;
            cur_q[1]    <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int unsigned s = 0; s < STAGES; s++) begin
                for (int unsigned c = 0; c < 2; c++) begin
                    x1_q[s][c] <= '0;
                    x2_q[s][c] <= '0;
                    y1_q[s][c] <= '0;
                    y2_q[s][c] <= '0;
                end
                for (int unsigned t = 0; t < NUM_TAPS; t++) begin
                    if (t == IDX_B0) begin
                        shd_q[s][t] <= COEF_PASS;
                        act_q[s][t] <= COEF_PASS;
                    end else begin
                        shd_q[s][t] <= '0;
                        act_q[s][t] <= '0;
                    end
                end
            end
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            tap_q       <= tap_d;
            ch_q        <= ch_d;
            cur_q       <= cur_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            shd_q       <= shd_d;
            act_q       <= act_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_audio_mac_sched.sv
// Directed and randomized checks of audio_mac_sched against a behavioural biquad model.
module tb_audio_mac_sched;

    localparam int STAGES = 2;
    localparam int LAT    = 12 * STAGES + 2;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               sample_ce = 1'b0;
    logic signed [15:0] in_l = '0, in_r = '0;
    logic [STAGES-1:0]  en = '1;
    logic               cfg_we = 1'b0;
    logic [3:0]         cfg_addr = '0;
    logic [17:0]        cfg_data = '0;
    logic signed [15:0] out_l, out_r;
    logic               out_valid, busy, overrun;

    always #5 clk = ~clk;

    audio_mac_sched #(.STAGES(STAGES), .FRAC(16)) dut (
        .clk(clk), .reset_n(reset_n), .sample_ce(sample_ce),
        .in_l(in_l), .in_r(in_r), .en(en),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .out_l(out_l), .out_r(out_r), .out_valid(out_valid),
        .busy(busy), .overrun(overrun)
    );

    int checks = 0, errors = 0;
    int m_sh [STAGES][5], m_act [STAGES][5];
    int m_x1 [STAGES][2], m_x2 [STAGES][2], m_y1 [STAGES][2], m_y2 [STAGES][2];
    int exp_l = 0, exp_r = 0;
    int got_l = 0, got_r = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int s = 0; s < STAGES; s++) begin
            for (int t = 0; t < 5; t++) begin
                m_sh[s][t]  = (t == 0) ? 65536 : 0;
                m_act[s][t] = m_sh[s][t];
            end
            for (int c = 0; c < 2; c++) begin
                m_x1[s][c] = 0; m_x2[s][c] = 0; m_y1[s][c] = 0; m_y2[s][c] = 0;
            end
        end
    endtask

    function automatic int narrow(input longint v);
        logic signed [15:0] t;
`ifdef AUDIO_SCHED_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
`else
        t = v[15:0];
        return int'(t);
`endif
    endfunction

    // Direct-form I biquad per stage and channel, with bypass leaving history alone.
    task automatic model_sample(input int l, input int r);
        int cur [2];
        longint acc;
        int yv;
        m_act = m_sh;
        cur[0] = l;
        cur[1] = r;
        for (int s = 0; s < STAGES; s++) begin
            for (int c = 0; c < 2; c++) begin
                if (en[s]) begin
                    acc = longint'(m_act[s][0]) * cur[c] + longint'(m_act[s][1]) * m_x1[s][c]
                        + longint'(m_act[s][2]) * m_x2[s][c] - longint'(m_act[s][3]) * m_y1[s][c]
                        - longint'(m_act[s][4]) * m_y2[s][c];
                    yv = narrow(acc >>> 16);
                    m_x2[s][c] = m_x1[s][c];
                    m_x1[s][c] = cur[c];
                    m_y2[s][c] = m_y1[s][c];
                    m_y1[s][c] = yv;
                    cur[c] = yv;
                end
            end
        end
        exp_l = cur[0];
        exp_r = cur[1];
    endtask

    task automatic write_coef(input int s, input int idx, input logic [17:0] d);
        logic signed [17:0] sd;
        cfg_addr = 4'((s << 3) | idx);
        cfg_data = d;
        cfg_we   = 1'b1;
        tick();
        cfg_we   = 1'b0;
        sd = d;
        if (idx < 5) m_sh[s][idx] = int'(sd);
    endtask

    task automatic start(input int l, input int r);
        in_l = 16'(l);
        in_r = 16'(r);
        sample_ce = 1'b1;
        tick();
        sample_ce = 1'b0;
        model_sample(l, r);
    endtask

    // n = cycles already elapsed since the sample_ce cycle.
    task automatic finish_sample(input int n0, input string tag);
        int n;
        n = n0;
        while (!out_valid && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, LAT);
        got_l = int'(out_l);
        got_r = int'(out_r);
        chk({tag, "_l"}, got_l, exp_l);
        chk({tag, "_r"}, got_r, exp_r);
        tick();
        chk({tag, "_pulse"}, int'(out_valid), 0);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        tick();
        model_reset();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic count_valid(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (out_valid) cnt++;
        end
    endtask

    initial begin
        int cnt;
        model_reset();
        repeat (3) tick();
        chk("rst_out_l", int'(out_l), 0);
        chk("rst_out_r", int'(out_r), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        reset_n = 1'b1;
        tick();

        en = 2'b11;
        start(1000, -1000);
        chk("pass_busy", int'(busy), 1);
        finish_sample(1, "pass");
        chk("pass_const_l", got_l, 1000);
        chk("pass_const_r", got_r, -1000);

        write_coef(0, 0, 18'd32768);
        start(1000, 400);
        repeat (3) tick();
        write_coef(0, 0, 18'd16384);
        finish_sample(5, "gain");
        chk("gain_const_l", got_l, 500);
        start(1000, 400);
        finish_sample(1, "gain2");
        chk("gain2_const_l", got_l, 250);

        start(100, 200);
        repeat (4) tick();
        in_l = 16'sd7777;
        sample_ce = 1'b1;
        tick();
        sample_ce = 1'b0;
        finish_sample(6, "ovr");
        chk("ovr_flag", int'(overrun), 1);
        count_valid(40, cnt);
        chk("ovr_single_valid", cnt, 0);
        chk("ovr_sticky", int'(overrun), 1);

        apply_reset();
        chk("ovr_cleared", int'(overrun), 0);
        start(300, -300);
        repeat (LAT - 2) tick();
        sample_ce = 1'b1;
        tick();
        sample_ce = 1'b0;
        chk("done_valid", int'(out_valid), 1);
        chk("done_l", int'(out_l), exp_l);
        chk("done_overrun", int'(overrun), 1);
        tick();
        chk("done_idle_busy", int'(busy), 0);
        count_valid(30, cnt);
        chk("done_ignored", cnt, 0);

        // 18'h20000 is -2.0 in Q2.16; a negative input makes the product +40000.
        apply_reset();
        write_coef(0, 0, 18'h20000);
        start(-20000, 5);
        finish_sample(1, "sat");
`ifdef AUDIO_SCHED_SAT_EN
        chk("sat_const_l", got_l, 32767);
`else
        chk("sat_const_l", got_l, -25536);
`endif

        apply_reset();
        write_coef(0, 3, 18'h38000);
        start(1000, 0); finish_sample(1, "rec0"); chk("rec0_const", got_l, 1000);
        start(0, 0);    finish_sample(1, "rec1"); chk("rec1_const", got_l, 500);
        start(0, 0);    finish_sample(1, "rec2"); chk("rec2_const", got_l, 250);
        en = 2'b10;
        start(1000, 0); finish_sample(1, "byp0"); chk("byp0_const", got_l, 1000);
        start(0, 0);    finish_sample(1, "byp1"); chk("byp1_const", got_l, 0);
        start(0, 0);    finish_sample(1, "byp2"); chk("byp2_const", got_l, 0);
        en = 2'b11;

        apply_reset();
        start(1234, -1234);
        repeat (9) tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_l", int'(out_l), 0);
        chk("midrst_r", int'(out_r), 0);
        chk("midrst_busy", int'(busy), 0);
        model_reset();
        tick();
        reset_n = 1'b1;
        count_valid(40, cnt);
        chk("midrst_no_valid", cnt, 0);
        start(1234, -1234);
        finish_sample(1, "midrst_next");

        apply_reset();
        for (int k = 0; k < 16; k++) begin
            for (int w = 0; w < 2; w++) begin
                write_coef($urandom_range(0, STAGES - 1), $urandom_range(0, 7),
                           18'($urandom_range(0, 262143)));
            end
            en = 2'($urandom_range(0, 3));
            start($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768);
            finish_sample(1, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
